// File: rtl/ukf_fx_pkg.sv
// Shared fixed-point definitions for the UKF accelerator datapath.
// Q2.30 signed format: 2 integer bits (including sign), 30 fractional bits.
package ukf_fx_pkg;

  localparam int DATA_W    = 32;
  localparam int INT_BITS  = 2;
  localparam int FRAC_BITS = 30;

  typedef logic signed [DATA_W-1:0]   fx_t;
  typedef logic signed [2*DATA_W-1:0] fx_wide_t;

  localparam fx_t FX_ONE = fx_t'(1 << FRAC_BITS);
  localparam fx_t FX_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // A rescaled product fits in fx_t only when its top DATA_W+1 bits are all equal
  function automatic logic fx_ovf(input fx_wide_t s);
    return !((&s[2*DATA_W-1:DATA_W-1]) || !(|s[2*DATA_W-1:DATA_W-1]));
  endfunction

endpackage

// File: rtl/fx_mul_arbiter_if.sv
// Request/response bus between the UKF requesters and the shared multiplier.
// master = requester side, slave = arbiter/multiplier side.
interface fx_mul_arbiter_if
  import ukf_fx_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_p;
  logic                    rsp_ovf;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_p, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_p, rsp_ovf, busy
  );

endinterface

// File: rtl/fx_mul_arbiter_rr.sv
// Round-robin arbiter with a registered priority pointer.
// The pointer moves one past the winner on every accepted grant, so the
// most recently served requester becomes the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic             flush,
  output logic [N_REQ-1:0] grant
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Search from the pointer upward with wrap; flush suppresses every grant
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((k + int'(ptr)) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
    if (flush) begin
      grant = '0;
    end
  end

  // Pointer steps past the winner only when a grant is actually taken
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance && !flush && found) begin
      ptr <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fx_mul_arbiter.sv
// Shared pipelined Q2.30 multiplier with round-robin request arbitration.
// Stage 0 registers the full-width product; optional middle stages are pure
// delay; the final register rescales, flags overflow and drives the response.
// Optional build macro: FX_MUL_ARBITER_SAT_EN clamps overflowed results to
// FX_MAX/FX_MIN instead of returning the wrapped low bits.
module fx_mul_arbiter
  import ukf_fx_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  fx_mul_arbiter_if.slave  bus
);

  logic [N_REQ-1:0] grant;
  logic             accept;
  fx_t              sel_a;
  fx_t              sel_b;
  fx_wide_t         issue_prod;

  logic             last_valid;
  logic [N_REQ-1:0] last_tag;
  fx_wide_t         last_prod;
  logic             dly_busy;

  fx_wide_t         s_wide;
  logic             s_ovf;
  fx_t              s_res;

  logic [N_REQ-1:0] rsp_valid_q;
  fx_t              rsp_p_q;
  logic             rsp_ovf_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (bus.req_valid),
    .advance (accept),
    .flush   (flush),
    .grant   (grant)
  );

  assign bus.req_ready = grant;
  assign accept        = |(bus.req_valid & grant);

  // One-hot operand select for the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = fx_t'(bus.req_a[i*DATA_W +: DATA_W]);
        sel_b = fx_t'(bus.req_b[i*DATA_W +: DATA_W]);
      end
    end
  end

  assign issue_prod = fx_wide_t'(sel_a) * fx_wide_t'(sel_b);

  generate
    if (MUL_LAT == 1) begin : g_nodly
      assign last_valid = accept;
      assign last_tag   = grant;
      assign last_prod  = issue_prod;
      assign dly_busy   = 1'b0;
    end else begin : g_dly
      logic [MUL_LAT-2:0] dly_valid;
      logic [N_REQ-1:0]   dly_tag  [MUL_LAT-1];
      fx_wide_t           dly_prod [MUL_LAT-1];

      // Product capture in stage 0, then a flushable delay line
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dly_valid <= '0;
          for (int s = 0; s < MUL_LAT-1; s++) begin
            dly_tag[s]  <= '0;
            dly_prod[s] <= '0;
          end
        end else begin
          dly_valid[0] <= accept & ~flush;
          dly_tag[0]   <= grant;
          dly_prod[0]  <= issue_prod;
          for (int s = 1; s < MUL_LAT-1; s++) begin
            dly_valid[s] <= dly_valid[s-1] & ~flush;
            dly_tag[s]   <= dly_tag[s-1];
            dly_prod[s]  <= dly_prod[s-1];
          end
        end
      end

      assign last_valid = dly_valid[MUL_LAT-2];
      assign last_tag   = dly_tag[MUL_LAT-2];
      assign last_prod  = dly_prod[MUL_LAT-2];
      assign dly_busy   = |dly_valid;
    end
  endgenerate

  assign s_wide = last_prod >>> FRAC_BITS;
  assign s_ovf  = fx_ovf(s_wide);

`ifdef FX_MUL_ARBITER_SAT_EN
  assign s_res = s_ovf ? (s_wide[2*DATA_W-1] ? FX_MIN : FX_MAX) : fx_t'(s_wide[DATA_W-1:0]);
`else
  assign s_res = fx_t'(s_wide[DATA_W-1:0]);
`endif

  // Response register: single-cycle tag strobe, data holds between results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      rsp_valid_q <= (last_valid && !flush) ? last_tag : '0;
      if (last_valid && !flush) begin
        rsp_p_q   <= s_res;
        rsp_ovf_q <= s_ovf;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.busy      = dly_busy | (|rsp_valid_q);

endmodule

// File: tb/tb_fx_mul_arbiter.sv
// Directed bench for fx_mul_arbiter: table of single-request products, then
// hand-written round-robin, wrap, flush and mid-flight reset sequences.
// Expected responses go into a queue that a negedge monitor drains in order.
module tb_fx_mul_arbiter;
  import ukf_fx_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 2;

`ifdef FX_MUL_ARBITER_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic flush;

  fx_mul_arbiter_if #(.N_REQ(N)) bus ();

  fx_mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [N-1:0]      tag;
    logic [DATA_W-1:0] p;
    logic              ovf;
  } exp_t;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p_wrap;
    logic [31:0] p_sat;
    logic        ovf;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*DATA_W-1:0] a,
                               input logic [N*DATA_W-1:0] b, input logic fl);
    bus.req_valid = valid;
    bus.req_a     = a;
    bus.req_b     = b;
    flush         = fl;
  endtask

  function automatic logic [N*DATA_W-1:0] place(input int idx, input logic [DATA_W-1:0] v);
    logic [N*DATA_W-1:0] r;
    r = '0;
    r[idx*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  task automatic push_exp(input logic [N-1:0] tag, input logic [31:0] p, input logic ovf);
    exp_t e;
    e.tag = tag;
    e.p   = p;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_tag", 32'(bus.rsp_valid), 32'(e.tag));
        checkOutput("rsp_p", bus.rsp_p, e.p);
        checkOutput("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.ovf));
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N*DATA_W-1:0] a_all;
    logic [N*DATA_W-1:0] b_all;
    logic [N-1:0]        exp_g;
    logic [31:0]         ovf_p;
    int                  lat;
    bit                  got;

    vecs[0] = '{0, 32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000, 1'b0};
    vecs[1] = '{2, 32'hC000_0000, 32'h2000_0000, 32'hE000_0000, 32'hE000_0000, 1'b0};
    vecs[2] = '{1, 32'h6000_0000, 32'h6000_0000, 32'h9000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{3, 32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0};
    vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[5] = '{1, 32'h7FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    vecs[6] = '{2, 32'h8000_0000, 32'h6000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1};
    vecs[7] = '{3, 32'hFFFF_FFFF, 32'h2000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    rstn = 1'b0;
    applyStimulus('0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_p", bus.rsp_p, 32'd0);
    checkOutput("reset_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_ready", 32'(bus.req_ready), 32'd0);
    rstn = 1'b1;

    // Single-request table: grant, latency and result per vector
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      applyStimulus(N'(1 << vecs[v].idx), place(vecs[v].idx, vecs[v].a),
                    place(vecs[v].idx, vecs[v].b), 1'b0);
      #1;
      checkOutput($sformatf("grant_v%0d", v), 32'(bus.req_ready), 32'(1 << vecs[v].idx));
      push_exp(N'(1 << vecs[v].idx), SAT_BUILD ? vecs[v].p_sat : vecs[v].p_wrap, vecs[v].ovf);
      @(posedge clk);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        if (lat == 0) applyStimulus('0, '0, '0, 1'b0);
        lat++;
        if (bus.rsp_valid != '0) got = 1'b1;
      end
      checkOutput($sformatf("latency_v%0d", v), 32'(lat), 32'(LAT));
    end

    // All four requesting for 8 cycles: strict rotation 0,1,2,3,0,1,2,3
    @(negedge clk);
    a_all = '0;
    b_all = '0;
    for (int i = 0; i < N; i++) begin
      a_all[i*DATA_W +: DATA_W] = 32'((i + 1) * 32'h0800_0000);
      b_all[i*DATA_W +: DATA_W] = 32'h4000_0000;
    end
    applyStimulus(4'hF, a_all, b_all, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("grant_rr%0d", c), 32'(bus.req_ready), 32'(1 << (c % 4)));
      push_exp(N'(1 << (c % 4)), 32'(((c % 4) + 1) * 32'h0800_0000), 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);

    // req1 alone, then req1+req3: expect 3, 1, 3 (pointer wraps 3 -> 0)
    applyStimulus(4'b0010, place(1, 32'h1000_0000), place(1, 32'h4000_0000), 1'b0);
    #1;
    checkOutput("grant_req1_first", 32'(bus.req_ready), 32'b0010);
    push_exp(4'b0010, 32'h1000_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(4'b1010, place(1, 32'h1800_0000) | place(3, 32'h3000_0000),
                  place(1, 32'h4000_0000) | place(3, 32'h4000_0000), 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = (c == 1) ? 4'b0010 : 4'b1000;
      checkOutput($sformatf("grant_wrap%0d", c), 32'(bus.req_ready), 32'(exp_g));
      push_exp(exp_g, (c == 1) ? 32'h1800_0000 : 32'h3000_0000, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);

    // Flush with one response in the output stage and one in stage 0
    ovf_p = SAT_BUILD ? 32'h7FFF_FFFF : 32'h9000_0000;
    applyStimulus(4'b0001, place(0, 32'h6000_0000), place(0, 32'h6000_0000), 1'b0);
    #1;
    checkOutput("grant_pre_flush0", 32'(bus.req_ready), 32'b0001);
    push_exp(4'b0001, ovf_p, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(4'b0010, place(1, 32'h1234_5678), place(1, 32'h4000_0000), 1'b0);
    #1;
    checkOutput("grant_pre_flush1", 32'(bus.req_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(4'b0100, place(2, 32'h1000_0000), place(2, 32'h4000_0000), 1'b1);
    #1;
    checkOutput("ready_during_flush", 32'(bus.req_ready), 32'd0);
    checkOutput("busy_before_flush", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_after_flush", 32'(bus.busy), 32'd0);
    checkOutput("rsp_valid_after_flush", 32'(bus.rsp_valid), 32'd0);
    applyStimulus(4'hF, '0, '0, 1'b0);
    #1;
    checkOutput("ptr_after_flush", 32'(bus.req_ready), 32'b0100);
    applyStimulus('0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);

    // Asynchronous reset with an operation in flight
    applyStimulus(4'b0100, place(2, 32'h2000_0000), place(2, 32'h4000_0000), 1'b0);
    #1;
    checkOutput("grant_pre_reset", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("busy_before_reset", 32'(bus.busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("async_rst_rsp_p", bus.rsp_p, 32'd0);
    checkOutput("async_rst_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
    checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(4'hF, '0, '0, 1'b0);
    #1;
    checkOutput("ptr_after_reset", 32'(bus.req_ready), 32'b0001);
    applyStimulus('0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);

    checkOutput("all_responses_seen", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
